// File: rtl/can_clic_dispatch.sv
// can_clic_dispatch: registers the arbiter winner into a req/ack handshake and keeps a nested threshold stack.
// Optional macro CAN_CLIC_LATE_ARRIVAL_EN lets a higher-priority winner replace a pending request.
module can_clic_dispatch #(
  parameter int NR_ENTRIES = 8,
  parameter int PRIO_W = 2,
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(NR_ENTRIES),
  parameter int D_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              is_interrupt,
  input  logic [IDX_W-1:0]  index,
  input  logic [PRIO_W-1:0] prio,
  output logic              irq_req,
  output logic [IDX_W-1:0]  irq_id,
  input  logic              irq_ack,
  input  logic              irq_ret,
  output logic [PRIO_W-1:0] threshold,
  output logic              clear_valid,
  output logic [IDX_W-1:0]  clear_id,
  output logic [D_W-1:0]    depth,
  output logic              underflow
);
  localparam int S_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic {IDLE, REQ} state_t;
  state_t state, next;
  logic [IDX_W-1:0] req_id;
  logic [PRIO_W-1:0] req_prio;
  logic [PRIO_W-1:0] stk [DEPTH];
  logic capture, late, push, chain, pop, full;
  logic [S_W-1:0] push_ptr, pop_ptr;
  assign full = depth == D_W'(DEPTH);
  assign push_ptr = S_W'(depth);
  assign pop_ptr = S_W'(depth - 1'b1);
  assign irq_req = state == REQ;
  assign irq_id = req_id;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    capture = 1'b0;
    late = 1'b0;
    push = 1'b0;
    chain = 1'b0;
    pop = 1'b0;
    if (state == IDLE) begin
      pop = irq_ret;
      capture = is_interrupt && !full;
      next = capture ? REQ : IDLE;
    end else begin
      push = irq_ack && !irq_ret;
      chain = irq_ack && irq_ret;
      pop = irq_ret && !irq_ack;
`ifdef CAN_CLIC_LATE_ARRIVAL_EN
      late = !irq_ack && !irq_ret && is_interrupt && prio > req_prio;
`else
      late = 1'b0;
`endif
      next = (irq_ack || irq_ret || !is_interrupt) ? IDLE : REQ;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      req_id <= '0;
      req_prio <= '0;
      threshold <= '0;
      depth <= '0;
      clear_valid <= 1'b0;
      clear_id <= '0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
    end else begin
      clear_valid <= push || chain;
      if (push || chain) begin
        threshold <= req_prio;
        clear_id <= req_id;
      end
      // capture only happens below DEPTH, so a push never overruns the stack
      if (push && !full) begin
        stk[push_ptr] <= threshold;
        depth <= depth + 1'b1;
      end
      if (pop) begin
        if (depth == '0) underflow <= 1'b1;
        else begin
          threshold <= stk[pop_ptr];
          depth <= depth - 1'b1;
        end
      end
      if (capture || late) begin
        req_id <= index;
        req_prio <= prio;
      end
    end
endmodule
